// File: rtl/trap_sequencer.sv
// Trap/MRET insertion sequencer: stalls fetch, drains the Execute-stage bus access,
// commits the trap CSR updates in one cycle, then redirects and flushes the pipeline.
module trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  input  logic        exec_busy,
  input  logic        redirect_ready,
  output logic        stall,
  output logic        bus_abort,
  output logic        trap_insert,
  output logic        mret_done,
  output logic        csr_trap_we,
  output logic        csr_mret_we,
  output logic [31:0] csr_mepc,
  output logic [31:0] csr_mcause,
  output logic [31:0] csr_mtval,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  // Handshakes: trap_req/mret_req are level requests held by the requester until the
  // matching trap_insert/mret_done pulse; redirect_valid holds with a stable redirect_pc
  // and the transfer completes on the first cycle redirect_ready is high.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kind_mret_q, kind_mret_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      val_q, val_d;
  logic [31:0]      rpc_q, rpc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kind_mret_q <= 1'b0;
      epc_q       <= '0;
      cause_q     <= '0;
      val_q       <= '0;
      rpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kind_mret_q <= kind_mret_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      val_q       <= val_d;
      rpc_q       <= rpc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    kind_mret_d    = kind_mret_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    val_d          = val_q;
    rpc_d          = rpc_q;
    bus_abort      = 1'b0;
    trap_insert    = 1'b0;
    mret_done      = 1'b0;
    csr_trap_we    = 1'b0;
    csr_mret_we    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // Trap has priority; a concurrent MRET stays requested and is taken afterwards.
        if (trap_req) begin
          epc_d       = trap_epc;
          cause_d     = trap_cause;
          val_d       = trap_val;
          rpc_d       = trap_pc;
          kind_mret_d = 1'b0;
          state_d     = DRAIN;
        end else if (mret_req) begin
          rpc_d       = mepc;
          kind_mret_d = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!exec_busy) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          bus_abort = 1'b1;
          cnt_d     = '0;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        if (kind_mret_q) begin
          mret_done   = 1'b1;
          csr_mret_we = 1'b1;
        end else begin
          trap_insert = 1'b1;
          csr_trap_we = 1'b1;
        end
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Gated by rst_n so every output reads zero while reset is asserted.
  assign stall       = rst_n & ((state_q != IDLE) | trap_req | mret_req);
  assign csr_mepc    = epc_q;
  assign csr_mcause  = cause_q;
  assign csr_mtval   = val_q;
  assign redirect_pc = rpc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed sequences with an expected-output queue built from a
// per-sequence timeline, plus literal latency/value checks.
module tb_trap_sequencer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_epc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_val = '0;
  logic        mret_req = 1'b0;
  logic [31:0] mepc = '0;
  logic        exec_busy = 1'b0;
  logic        redirect_ready = 1'b0;
  logic        stall, bus_abort, trap_insert, mret_done, csr_trap_we, csr_mret_we;
  logic        flush, redirect_valid;
  logic [31:0] csr_mepc, csr_mcause, csr_mtval, redirect_pc;
  logic [1:0]  dbg_state;

  trap_sequencer #(.DRAIN_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_pc(trap_pc),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_val(trap_val),
    .mret_req(mret_req), .mepc(mepc), .exec_busy(exec_busy),
    .redirect_ready(redirect_ready), .stall(stall), .bus_abort(bus_abort),
    .trap_insert(trap_insert), .mret_done(mret_done), .csr_trap_we(csr_trap_we),
    .csr_mret_we(csr_mret_we), .csr_mepc(csr_mepc), .csr_mcause(csr_mcause),
    .csr_mtval(csr_mtval), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        stall;
    logic        bus_abort;
    logic        trap_insert;
    logic        mret_done;
    logic        csr_trap_we;
    logic        csr_mret_we;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mcause;
    logic [31:0] csr_mtval;
    logic [31:0] redirect_pc;
  } obs_t;

  logic [135:0] exp_q[$];
  string        lit_name_q[$];
  logic [31:0]  lit_act_q[$];
  logic [31:0]  lit_exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int commit_cyc = 0;
  int abort_total = 0;
  int rv_total = 0;
  int seq_start = 0;

  // Architectural view of what the sequencer has captured so far.
  logic [31:0] m_epc = '0, m_cause = '0, m_val = '0, m_rpc = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached (act=expired, exp=finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / compare ----------------
  function automatic obs_t sample_out();
    return obs_t'({stall, bus_abort, trap_insert, mret_done, csr_trap_we, csr_mret_we,
                   flush, redirect_valid, csr_mepc, csr_mcause, csr_mtval, redirect_pc});
  endfunction

  function automatic logic [31:0] any_out();
    return 32'(|{stall, bus_abort, trap_insert, mret_done, csr_trap_we, csr_mret_we,
                 flush, redirect_valid, csr_mepc, csr_mcause, csr_mtval, redirect_pc});
  endfunction

  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    string n;
    logic [31:0] la;
    logic [31:0] le;
    if (csr_trap_we || csr_mret_we) commit_cyc = cyc;
    if (bus_abort) abort_total = abort_total + 1;
    if (redirect_valid) rv_total = rv_total + 1;
    if (exp_q.size() > 0) begin
      e = obs_t'(exp_q.pop_front());
      a = sample_out();
      vectors = vectors + 1;
      if (a !== e) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs cyc=%0d act=%h exp=%h (stall..rv bits act=%b exp=%b)",
                 cyc, a, e, a[135:128], e[135:128]);
      end
    end
    while (lit_name_q.size() > 0) begin
      n  = lit_name_q.pop_front();
      la = lit_act_q.pop_front();
      le = lit_exp_q.pop_front();
      vectors = vectors + 1;
      if (la !== le) begin
        miscompares = miscompares + 1;
        $display("FAIL %s act=%h exp=%h", n, la, le);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
    lit_name_q.push_back(n);
    lit_act_q.push_back(act);
    lit_exp_q.push_back(exp);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      trap_req       = 1'b0;
      mret_req       = 1'b0;
      trap_pc        = $urandom();
      trap_epc       = $urandom();
      trap_cause     = $urandom();
      trap_val       = $urandom();
      mepc           = $urandom();
      exec_busy      = 1'($urandom_range(0, 1));
      redirect_ready = 1'($urandom_range(0, 1));
      e = '0;
      e.csr_mepc    = m_epc;
      e.csr_mcause  = m_cause;
      e.csr_mtval   = m_val;
      e.redirect_pc = m_rpc;
      exp_q.push_back(e);
    end
  endtask

  // One full sequence: request in t=0, drain with exec_busy high for b drain cycles,
  // commit, then redirect_ready held low for r redirect cycles.
  task automatic run_seq(input bit is_trap, input bit mret_also, input int b, input int r,
                         input logic [31:0] pc, input logic [31:0] epc,
                         input logic [31:0] cause, input logic [31:0] val,
                         input logic [31:0] mepc_v);
    int  d;
    bit  ab;
    bit  held;
    obs_t e;
    d  = (b + 1 < T) ? b + 1 : T;
    ab = (b >= T);
    for (int t = 0; t < d + 3 + r; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) seq_start = cyc;
      if (t == 1) begin
        if (is_trap) begin
          m_epc   = epc;
          m_cause = cause;
          m_val   = val;
          m_rpc   = pc;
        end else begin
          m_rpc = mepc_v;
        end
      end
      held       = (t <= d + 1);
      trap_req   = is_trap & held;
      mret_req   = (!is_trap & held) | mret_also;
      trap_pc    = (t == 0) ? pc : $urandom();
      trap_epc   = (t == 0) ? epc : $urandom();
      trap_cause = (t == 0) ? cause : $urandom();
      trap_val   = (t == 0) ? val : $urandom();
      mepc       = (t == 0) ? mepc_v : $urandom();
      exec_busy  = (t >= 1 && t <= d) ? (t <= b) : 1'($urandom_range(0, 1));
      redirect_ready = (t >= d + 2) ? (t == d + 2 + r) : 1'($urandom_range(0, 1));
      e = '0;
      e.stall          = 1'b1;
      e.bus_abort      = ab && (t == d);
      e.trap_insert    = is_trap && (t == d + 1);
      e.csr_trap_we    = is_trap && (t == d + 1);
      e.mret_done      = !is_trap && (t == d + 1);
      e.csr_mret_we    = !is_trap && (t == d + 1);
      e.flush          = (t >= d + 2);
      e.redirect_valid = (t >= d + 2);
      e.csr_mepc       = m_epc;
      e.csr_mcause     = m_cause;
      e.csr_mtval      = m_val;
      e.redirect_pc    = m_rpc;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ab0;
    int rv0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_outputs", any_out(), 32'h0);
    lit("reset_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // minimum-latency trap
    rv0 = rv_total;
    run_seq(1'b1, 1'b0, 0, 0, 32'h100, 32'h2000, 32'h2, 32'hDEADBEEF, 32'h0);
    settle();
    lit("t1_commit_latency", 32'(commit_cyc - seq_start), 32'd2);
    lit("t1_redirect_cycles", 32'(rv_total - rv0), 32'd1);
    lit("t1_csr_mepc", csr_mepc, 32'h2000);
    lit("t1_csr_mcause", csr_mcause, 32'h2);
    lit("t1_csr_mtval", csr_mtval, 32'hDEADBEEF);
    lit("t1_redirect_pc", redirect_pc, 32'h100);
    idle(1);

    // short drain: busy for 3 drain cycles
    ab0 = abort_total;
    run_seq(1'b1, 1'b0, 3, 0, 32'h200, 32'h3000, 32'h5, 32'h1234, 32'h0);
    settle();
    lit("t2_commit_latency", 32'(commit_cyc - seq_start), 32'd5);
    lit("t2_no_abort", 32'(abort_total - ab0), 32'd0);
    idle(2);

    // busy released exactly in the last allowed drain cycle: no abort
    ab0 = abort_total;
    run_seq(1'b1, 1'b0, T - 1, 1, 32'h240, 32'h3100, 32'h7, 32'h55, 32'h0);
    settle();
    lit("t3a_commit_latency", 32'(commit_cyc - seq_start), 32'd17);
    lit("t3a_no_abort", 32'(abort_total - ab0), 32'd0);
    idle(1);

    // busy stuck: timeout abort in the 16th drain cycle
    ab0 = abort_total;
    run_seq(1'b1, 1'b0, 40, 0, 32'h280, 32'h3200, 32'hB, 32'h66, 32'h0);
    settle();
    lit("t3b_commit_latency", 32'(commit_cyc - seq_start), 32'd17);
    lit("t3b_one_abort", 32'(abort_total - ab0), 32'd1);
    idle(1);

    // trap and MRET together: trap first, MRET back-to-back afterwards
    run_seq(1'b1, 1'b1, 1, 1, 32'h300, 32'h5000, 32'h8000_0007, 32'h0, 32'h0);
    run_seq(1'b0, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4000);
    settle();
    lit("t4_mret_latency", 32'(commit_cyc - seq_start), 32'd2);
    lit("t4_mret_redirect_pc", redirect_pc, 32'h4000);
    lit("t4_csr_mepc_kept", csr_mepc, 32'h5000);
    idle(1);

    // standalone MRET with a drain
    run_seq(1'b0, 1'b0, 2, 2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8888);
    idle(1);

    // redirect_ready low for 5 cycles
    rv0 = rv_total;
    run_seq(1'b1, 1'b0, 0, 5, 32'h600, 32'h6000, 32'h3, 32'hCAFE, 32'h0);
    settle();
    lit("t6_redirect_cycles", 32'(rv_total - rv0), 32'd6);
    lit("t6_redirect_pc", redirect_pc, 32'h600);
    idle(1);

    // async reset while in REDIRECT
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      trap_req       = (t <= 2);
      trap_pc        = 32'h700;
      trap_epc       = 32'h7000;
      trap_cause     = 32'h4;
      trap_val       = 32'h77;
      exec_busy      = 1'b0;
      redirect_ready = 1'b0;
    end
    #2;
    lit("t5_redirect_before_reset", 32'(redirect_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    lit("t5_async_outputs_zero", any_out(), 32'h0);
    lit("t5_async_state_idle", 32'(dbg_state), 32'h0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_epc   = '0;
    m_cause = '0;
    m_val   = '0;
    m_rpc   = '0;
    idle(3);
    run_seq(1'b1, 1'b0, 0, 0, 32'h900, 32'h9000, 32'h1, 32'h99, 32'h0);
    idle(2);

    settle();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
